object_spawn_scheduler: RTL and testbench

- Sequences a stage's object-spawn pattern into the multi-object trigger runtime.
- Walks a pattern ROM in address order and holds each entry until the stage timer reaches its spawn time.
- Presents the entry's object fields and performs the sync/update handshake the runtime uses to claim a free object slot.
- Tracks stage time, supports pause, and counts spawns the runtime fails to acknowledge.

---
 rtl/object_spawn_if.sv | 26 ++
 rtl/object_spawn_scheduler.sv | 175 +++++++++++++++++
 tb/tb_object_spawn_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/object_spawn_if.sv
// Spawn handshake between the scheduler (master) and the multi-object trigger runtime (slave).
// Carries the object fields, the active-low sync request and the runtime's update acknowledge.
interface object_spawn_if;
  logic [2:0] object_movement_direction;
  logic [9:0] object_pos_x;
  logic [9:0] object_pos_y;
  logic [9:0] object_w;
  logic [9:0] object_h;
  logic [4:0] object_speed;
  logic [7:0] object_destroy_time;
  logic [1:0] object_destroy_trigger;
  logic       sync_object_position;
  logic       update_object_position;

  modport master (
    output object_movement_direction, object_pos_x, object_pos_y, object_w, object_h,
    output object_speed, object_destroy_time, object_destroy_trigger, sync_object_position,
    input  update_object_position
  );

  modport slave (
    input  object_movement_direction, object_pos_x, object_pos_y, object_w, object_h,
    input  object_speed, object_destroy_time, object_destroy_trigger, sync_object_position,
    output update_object_position
  );
endinterface

// File: rtl/object_spawn_scheduler.sv
// Walks a stage's spawn-pattern ROM, waits for each entry's spawn time and hands it to the
// object runtime over the sync/update handshake; tracks stage time and counts unacked spawns.
module object_spawn_scheduler #(
  parameter int ADDR_W      = 8,
  parameter int ACK_TIMEOUT = 64,
  parameter int TIME_W      = 16
) (
  input  logic                clk_calculation,
  input  logic                reset,
  input  logic                centi_tick,
  input  logic                start,
  input  logic                pause,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [74:0]         rom_entry,
  object_spawn_if.master      spawn_if,
  output logic [TIME_W-1:0]   stage_time,
  output logic                busy,
  output logic                done,
  output logic [7:0]          drop_count
);

  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, WAIT_TIME, ISSUE, RELEASE} state_e;

  typedef struct packed {
    logic [2:0] dir;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [9:0] w;
    logic [9:0] h;
    logic [4:0] speed;
    logic [7:0] destroy_time;
    logic [1:0] destroy_trigger;
  } obj_t;

  // Field order mirrors the ROM word so a straight cast unpacks it.
  typedef struct packed {
    logic [15:0] spawn_time;
    obj_t        obj;
    logic        last;
  } entry_t;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  entry_t              entry_q, entry_d;
  obj_t                obj_q, obj_d;
  logic                sync_q, sync_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [TIME_W-1:0]   time_q, time_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7:0]          drop_q, drop_d;
  logic                due;

  assign due = (time_q >= TIME_W'(entry_q.spawn_time));

  // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    entry_d = entry_q;
    obj_d   = obj_q;
    sync_d  = sync_q;
    tmo_d   = tmo_q;
    time_d  = time_q;
    busy_d  = busy_q;
    done_d  = done_q;
    drop_d  = drop_q;

    if (state_q == IDLE && start) begin
      time_d = '0;
    end else if (centi_tick && busy_q && !pause && time_q != '1) begin
      time_d = time_q + TIME_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          drop_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        entry_d = entry_t'(rom_entry);
        // The top address has no successor, so it always ends the pattern.
        if (addr_q == '1) entry_d.last = 1'b1;
        state_d = WAIT_TIME;
      end
      WAIT_TIME: begin
        if (due && !pause) begin
          obj_d   = entry_q.obj;
          sync_d  = 1'b0;
          tmo_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (spawn_if.update_object_position) begin
          sync_d  = 1'b1;
          state_d = RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          sync_d  = 1'b1;
          if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          state_d = RELEASE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RELEASE: begin
        if (!spawn_if.update_object_position) begin
          if (entry_q.last) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use <= so every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk_calculation) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      // NOTE: the entry register is a single word, so resetting it is cheap and keeps it X-free.
      entry_q <= '0;
      obj_q   <= '0;
      sync_q  <= 1'b1;
      tmo_q   <= '0;
      time_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      entry_q <= entry_d;
      obj_q   <= obj_d;
      sync_q  <= sync_d;
      tmo_q   <= tmo_d;
      time_q  <= time_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign rom_addr   = addr_q;
  assign stage_time = time_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign drop_count = drop_q;

  assign spawn_if.sync_object_position      = sync_q;
  assign spawn_if.object_movement_direction = obj_q.dir;
  assign spawn_if.object_pos_x              = obj_q.pos_x;
  assign spawn_if.object_pos_y              = obj_q.pos_y;
  assign spawn_if.object_w                  = obj_q.w;
  assign spawn_if.object_h                  = obj_q.h;
  assign spawn_if.object_speed              = obj_q.speed;
  assign spawn_if.object_destroy_time       = obj_q.destroy_time;
  assign spawn_if.object_destroy_trigger    = obj_q.destroy_trigger;

endmodule

// File: tb/tb_object_spawn_scheduler.sv
// Bench for object_spawn_scheduler: synchronous ROM and acknowledging runtime models,
// a scoreboard of expected spawns checked on every sync fall, and directed corner sequences.
module tb_object_spawn_scheduler;
  localparam int ADDR_W      = 8;
  localparam int ACK_TIMEOUT = 64;
  localparam int TIME_W      = 16;
  localparam int TICK_DIV    = 16;
  localparam int ACK_DELAY   = 3;

  typedef struct {
    logic [74:0] entry;
    int          exp_time;
  } vec_t;

  logic                clk_calculation = 1'b0;
  logic                reset = 1'b1;
  logic                centi_tick = 1'b0;
  logic                start = 1'b0;
  logic                pause = 1'b0;
  logic [ADDR_W-1:0]   rom_addr;
  logic [74:0]         rom_entry = '0;
  logic [TIME_W-1:0]   stage_time;
  logic                busy;
  logic                done;
  logic [7:0]          drop_count;

  object_spawn_if sif ();

  object_spawn_scheduler #(
    .ADDR_W(ADDR_W), .ACK_TIMEOUT(ACK_TIMEOUT), .TIME_W(TIME_W)
  ) dut (
    .clk_calculation(clk_calculation),
    .reset          (reset),
    .centi_tick     (centi_tick),
    .start          (start),
    .pause          (pause),
    .rom_addr       (rom_addr),
    .rom_entry      (rom_entry),
    .spawn_if       (sif),
    .stage_time     (stage_time),
    .busy           (busy),
    .done           (done),
    .drop_count     (drop_count)
  );

  always #5 clk_calculation = ~clk_calculation;

  logic [74:0] rom [0:(1<<ADDR_W)-1];
  always @(posedge clk_calculation) rom_entry <= rom[rom_addr];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc = 0, issue_n = 0, fall_cyc = 0, rise_cyc = -1;
  int   ticks_seen = 0, ticks_done = 0, tick_div = 0, low_cnt = 0;
  bit   ack_en = 1'b1;
  bit   prev_sync = 1'b1;
  int   low_len_q[$];
  int   gap_q[$];
  int   issue_tick[$];
  vec_t exp_q[$];
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [57:0] cur_fields();
    return {sif.object_movement_direction, sif.object_pos_x, sif.object_pos_y, sif.object_w,
            sif.object_h, sif.object_speed, sif.object_destroy_time, sif.object_destroy_trigger};
  endfunction

  function automatic logic [74:0] mk(input int t, input int x, input bit last);
    return {16'(t), 3'(x), 10'(x * 37), 10'(x * 91 + 5), 10'(x + 16), 10'(x * 3 + 8),
            5'(x + 1), 8'(x * 11), 2'(x), last};
  endfunction

  // One clock: observe outputs at the falling edge, then drive the runtime ack and centi_tick.
  task automatic step();
    vec_t e;
    @(negedge clk_calculation);
    cyc++;
    ticks_done = ticks_seen;
    if (prev_sync && !sif.sync_object_position) begin
      issue_n++;
      issue_tick.push_back(ticks_done);
      if (rise_cyc >= 0) gap_q.push_back(cyc - rise_cyc);
      fall_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("issue_fields", cur_fields(), e.entry[58:1]);
        check("issue_time", stage_time, e.exp_time);
      end
    end
    if (!prev_sync && sif.sync_object_position) begin
      low_len_q.push_back(cyc - fall_cyc);
      rise_cyc = cyc;
    end
    prev_sync = sif.sync_object_position;

    if (!sif.sync_object_position) begin
      low_cnt++;
      sif.update_object_position = ack_en && (low_cnt >= ACK_DELAY);
    end else begin
      low_cnt = 0;
      sif.update_object_position = 1'b0;
    end

    if (tick_div == TICK_DIV - 1) begin
      centi_tick = 1'b1;
      tick_div   = 0;
      ticks_seen++;
    end else begin
      centi_tick = 1'b0;
      tick_div++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    rise_cyc = -1;
    low_len_q.delete();
    gap_q.delete();
    issue_tick.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      rom[i] = vecs[first + i].entry;
      exp_q.push_back(vecs[first + i]);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin step(); n++; end
    check("done_reached", done, 1);
  endtask

  task automatic wait_stage(input int value, input int budget);
    int n = 0;
    while (stage_time != TIME_W'(value) && n < budget) begin step(); n++; end
    check("stage_reached", stage_time, value);
  endtask

  task automatic wait_issue(input int target, input int budget);
    int n = 0;
    while (issue_n < target && n < budget) begin step(); n++; end
    check("issue_seen", issue_n >= target, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad, base, tp, tr, s0, k0;
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = '0;
    sif.update_object_position = 1'b0;

    // {ROM word, expected stage_time at issue}; rows are grouped per sequence below.
    vecs[0] = '{mk(5, 1, 1'b0), 5};
    vecs[1] = '{mk(5, 2, 1'b0), 5};
    vecs[2] = '{mk(20, 3, 1'b1), 20};
    vecs[3] = '{mk(10, 4, 1'b1), 10};
    vecs[4] = '{mk(2, 5, 1'b0), 2};
    vecs[5] = '{mk(9, 6, 1'b1), 9};
    vecs[6] = '{mk(3, 7, 1'b0), 3};
    vecs[7] = '{mk(4, 8, 1'b1), 4};
    vecs[8] = '{mk(1, 9, 1'b0), 1};
    vecs[9] = '{mk(12, 10, 1'b1), 12};

    // Reset values, then idle without start.
    do_reset();
    check("rst_sync", sif.sync_object_position, 1);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_drop", drop_count, 0);
    check("rst_stage_time", stage_time, 0);
    check("rst_fields", cur_fields(), 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sif.sync_object_position !== 1'b1 || rom_addr !== '0 || busy !== 1'b0 || drop_count !== 8'd0)
        bad++;
    end
    check("idle_bad_cycles", bad, 0);
    check("idle_stage_time", stage_time, 0);

    // Three entries: two share spawn time 5 and go back-to-back, the last waits for 20.
    load(0, 3);
    pulse_start();
    check("run_busy", busy, 1);
    wait_done(3000);
    check("run_busy_after", busy, 0);
    check("run_sb_empty", exp_q.size(), 0);
    check("run_issue_count", low_len_q.size(), 3);
    for (int i = 0; i < 3; i++) check("run_ack_sync_low", low_len_q[i], ACK_DELAY);
    // Ack cycle + RELEASE, FETCH, LATCH, WAIT_TIME = 5 cycles, i.e. sync high for 4.
    check("run_release_gap", gap_q[0], 4);
    check("run_drop", drop_count, 0);
    repeat (10) step();
    check("run_done_sticky", done, 1);

    // Restart from done without reset, then pause the timer at 8 for 50 ticks.
    load(3, 1);
    pulse_start();
    check("restart_done_clear", done, 0);
    check("restart_stage_time", stage_time, 0);
    check("restart_rom_addr", rom_addr, 0);
    wait_stage(8, 1000);
    pause = 1'b1;
    base = issue_n;
    tp = ticks_done;
    for (int n = 0; n < 2000 && ticks_done - tp < 50; n++) step();
    check("pause_ticks_elapsed", ticks_done - tp >= 50, 1);
    check("pause_stage_held", stage_time, 8);
    check("pause_no_issue", issue_n, base);
    check("pause_sync_idle", sif.sync_object_position, 1);
    pause = 1'b0;
    tr = ticks_done;
    wait_issue(base + 1, 500);
    check("pause_ticks_to_issue", issue_tick[issue_tick.size() - 1] - tr, 2);
    wait_done(200);
    check("pause_sb_empty", exp_q.size(), 0);

    // Runtime never acks the first entry: timeout, drop, continue with the next.
    do_reset();
    load(4, 2);
    ack_en = 1'b0;
    pulse_start();
    for (int n = 0; n < 1000 && low_len_q.size() < 1; n++) step();
    check("tmo_rise_seen", low_len_q.size(), 1);
    check("tmo_sync_low", low_len_q[0], ACK_TIMEOUT);
    check("tmo_drop", drop_count, 1);
    check("tmo_busy", busy, 1);
    ack_en = 1'b1;
    wait_done(500);
    check("tmo_drop_final", drop_count, 1);
    check("tmo_next_acked", low_len_q[1], ACK_DELAY);
    check("tmo_sb_empty", exp_q.size(), 0);

    // Reset while an issue is outstanding, then restart from address 0.
    do_reset();
    load(6, 2);
    ack_en = 1'b0;
    pulse_start();
    wait_issue(issue_n + 1, 500);
    repeat (5) step();
    check("mid_issue_sync", sif.sync_object_position, 0);
    reset = 1'b1;
    step();
    check("mid_rst_sync", sif.sync_object_position, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fields", cur_fields(), 0);
    check("mid_rst_rom_addr", rom_addr, 0);
    check("mid_rst_stage_time", stage_time, 0);
    reset = 1'b0;
    check("mid_rst_pending", exp_q.size(), 1);
    exp_q.delete();
    load(6, 2);
    ack_en = 1'b1;
    pulse_start();
    wait_done(1000);
    check("mid_rst_sb_empty", exp_q.size(), 0);

    // start while busy is ignored: timer keeps counting, address stays on entry 1.
    do_reset();
    load(8, 2);
    pulse_start();
    wait_stage(4, 1000);
    check("busy_rom_addr_before", rom_addr, 1);
    s0 = int'(stage_time);
    k0 = ticks_done;
    pulse_start();
    repeat (40) step();
    check("busy_start_stage_time", stage_time, s0 + (ticks_done - k0));
    check("busy_start_rom_addr", rom_addr, 1);
    check("busy_start_busy", busy, 1);
    wait_done(1000);
    check("busy_start_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
